// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - recovers pixel coordinates and lock status from a VGA sync/colour stream
module vga_sync_decoder #(
    parameter int H_TOTAL = 800,
    parameter int H_VIS   = 640,
    parameter int H_SS    = 656,
    parameter int H_SE    = 752,
    parameter int V_TOTAL = 525,
    parameter int V_VIS   = 480,
    parameter int V_SS    = 490,
    parameter int V_SE    = 492
) (
    input  logic        CLK,
    input  logic        RST_BTN,
    input  logic        i_pix_stb,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic [11:0] i_rgb,
    output logic [9:0]  o_x,
    output logic [9:0]  o_y,
    output logic [11:0] o_rgb,
    output logic        o_de,
    output logic        o_frame_start,
    output logic        o_locked,
    output logic        o_err,
    output logic [7:0]  o_err_cnt
);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] HVIS_C = 10'(H_VIS);
    localparam logic [9:0] VVIS_C = 10'(V_VIS);
    localparam logic [9:0] HSS_C  = 10'(H_SS);
    localparam logic [9:0] HSE_C  = 10'(H_SE);
    localparam logic [9:0] VSS_C  = 10'(V_SS);
    localparam logic [9:0] VSE_C  = 10'(V_SE);

    typedef enum logic [1:0] {SEARCH, H_ACQ, V_ACQ, LOCKED} state_t;

    state_t      state_q, state_d;
    logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [9:0]  hn, vn;
    logic        hs_q, vs_q;
    logic        arm_q, arm_d;
    logic [9:0]  x_q, y_q;
    logic [11:0] rgb_q;
    logic        de_q, fs_q, err_q;
    logic [7:0]  err_cnt_q;
    logic        hs_fall, hs_rise, vs_fall, vs_rise, viol;

    always_comb begin
        hn = (hcnt_q == H_LAST) ? 10'd0 : hcnt_q + 10'd1;
        vn = vcnt_q;
        if (hn == 10'd0) begin
            vn = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
        end

        hs_fall = i_pix_stb & hs_q & ~i_hs;
        hs_rise = i_pix_stb & ~hs_q & i_hs;
        vs_fall = i_pix_stb & vs_q & ~i_vs;
        vs_rise = i_pix_stb & ~vs_q & i_vs;

        hcnt_d = hs_fall ? HSS_C : hn;
        vcnt_d = vs_fall ? VSS_C : vn;

        // Predictions are compared before any re-anchoring load is applied.
        viol = (state_q == LOCKED) &
               ((hs_fall & (hn != HSS_C)) |
                (hs_rise & (hn != HSE_C)) |
                (vs_fall & ((vn != VSS_C) | (hn != 10'd0))) |
                (vs_rise & ((vn != VSE_C) | (hn != 10'd0))) |
                (i_pix_stb & ~i_hs & (hn == HSE_C)));
    end

    always_comb begin
        state_d = state_q;
        arm_d   = arm_q;
        case (state_q)
            SEARCH: begin
                arm_d = 1'b0;
                if (hs_fall) state_d = H_ACQ;
            end
            H_ACQ: begin
                if (hs_fall && hn == HSS_C) state_d = V_ACQ;
            end
            V_ACQ: begin
                if (vs_fall) begin
                    if (!arm_q) begin
                        arm_d = 1'b1;
                    end else if (vn == VSS_C && hn == 10'd0) begin
                        state_d = LOCKED;
                        arm_d   = 1'b0;
                    end else begin
                        arm_d = 1'b0;
                    end
                end
            end
            LOCKED: begin
                if (viol) state_d = SEARCH;
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST_BTN) begin
            state_q   <= SEARCH;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            arm_q     <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            rgb_q     <= '0;
            de_q      <= 1'b0;
            fs_q      <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            fs_q  <= 1'b0;
            err_q <= 1'b0;
            if (i_pix_stb) begin
                state_q <= state_d;
                hcnt_q  <= hcnt_d;
                vcnt_q  <= vcnt_d;
                hs_q    <= i_hs;
                vs_q    <= i_vs;
                arm_q   <= arm_d;
                x_q     <= hcnt_d;
                y_q     <= vcnt_d;
                rgb_q   <= i_rgb;
                de_q    <= (state_d == LOCKED) && (hcnt_d < HVIS_C) && (vcnt_d < VVIS_C);
                fs_q    <= (state_d == LOCKED) && (hcnt_d == 10'd0) && (vcnt_d == 10'd0);
                err_q   <= viol;
                if (viol && err_cnt_q != 8'hFF) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end
        end
    end

    assign o_x           = x_q;
    assign o_y           = y_q;
    assign o_rgb         = rgb_q;
    assign o_de          = de_q;
    assign o_frame_start = fs_q;
    assign o_locked      = (state_q == LOCKED);
    assign o_err         = err_q;
    assign o_err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - randomized-timing bench for vga_sync_decoder on a reduced raster
module tb_vga_sync_decoder;

    localparam int HT  = 8;
    localparam int HV  = 4;
    localparam int HSS = 5;
    localparam int HSE = 7;
    localparam int VT  = 5;
    localparam int VV  = 3;
    localparam int VSS = 3;
    localparam int VSE = 4;

    logic        CLK = 1'b0;
    logic        RST_BTN;
    logic        i_pix_stb;
    logic        i_hs;
    logic        i_vs;
    logic [11:0] i_rgb;
    logic [9:0]  o_x;
    logic [9:0]  o_y;
    logic [11:0] o_rgb;
    logic        o_de;
    logic        o_frame_start;
    logic        o_locked;
    logic        o_err;
    logic [7:0]  o_err_cnt;

    always #5 CLK = ~CLK;

    vga_sync_decoder #(
        .H_TOTAL(HT), .H_VIS(HV), .H_SS(HSS), .H_SE(HSE),
        .V_TOTAL(VT), .V_VIS(VV), .V_SS(VSS), .V_SE(VSE)
    ) dut (
        .CLK          (CLK),
        .RST_BTN      (RST_BTN),
        .i_pix_stb    (i_pix_stb),
        .i_hs         (i_hs),
        .i_vs         (i_vs),
        .i_rgb        (i_rgb),
        .o_x          (o_x),
        .o_y          (o_y),
        .o_rgb        (o_rgb),
        .o_de         (o_de),
        .o_frame_start(o_frame_start),
        .o_locked     (o_locked),
        .o_err        (o_err),
        .o_err_cnt    (o_err_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int gx, gy;
    int max_gap  = 2;
    int lat;
    bit m_locked;
    int m_hsf, m_vsf, m_errs;
    bit m_prev_hs, m_prev_vs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_locked  = 1'b0;
        m_hsf     = 0;
        m_vsf     = 0;
        m_errs    = 0;
        m_prev_hs = 1'b1;
        m_prev_vs = 1'b1;
    endtask

    task automatic check_reset_outputs();
        check("rst_x", o_x, 0);
        check("rst_y", o_y, 0);
        check("rst_rgb", o_rgb, 0);
        check("rst_de", o_de, 0);
        check("rst_fs", o_frame_start, 0);
        check("rst_locked", o_locked, 0);
        check("rst_err", o_err, 0);
        check("rst_err_cnt", o_err_cnt, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            i_pix_stb = 1'b0;
            @(posedge CLK);
            #1;
            check("idle_err", o_err, 0);
            check("idle_fs", o_frame_start, 0);
            check("idle_locked", o_locked, m_locked);
        end
    endtask

    // One pixel of the raster at (gx,gy); viol marks a strobe the bench has made illegal.
    task automatic pixel(input bit widen, input bit viol);
        bit hs, vs, hf, vf, was_locked;
        logic [11:0] rgb;
        idle($urandom_range(max_gap, 0));
        hs  = !(gx >= HSS && (gx < HSE || widen));
        vs  = !(gy >= VSS && gy < VSE);
        rgb = 12'($urandom);
        i_pix_stb = 1'b1;
        i_hs      = hs;
        i_vs      = vs;
        i_rgb     = rgb;
        @(posedge CLK);
        #1;
        i_pix_stb = 1'b0;

        hf = m_prev_hs && !hs;
        vf = m_prev_vs && !vs;
        m_prev_hs  = hs;
        m_prev_vs  = vs;
        was_locked = m_locked;
        if (m_locked && viol) begin
            m_locked = 1'b0;
            m_hsf    = 0;
            m_vsf    = 0;
            if (m_errs < 255) m_errs++;
        end else if (!m_locked) begin
            // Lock needs two hsync falls, then two vsync falls.
            if (hf) m_hsf++;
            if (vf && m_hsf >= 2) m_vsf++;
            if (m_vsf == 2) m_locked = 1'b1;
        end

        check("locked", o_locked, m_locked);
        check("err", o_err, was_locked && viol);
        check("err_cnt", o_err_cnt, m_errs);
        check("rgb", o_rgb, rgb);
        check("de", o_de, m_locked && gx < HV && gy < VV);
        check("frame_start", o_frame_start, m_locked && gx == 0 && gy == 0);
        if (m_locked) begin
            check("x", o_x, gx);
            check("y", o_y, gy);
        end

        gx++;
        if (gx == HT) begin
            gx = 0;
            gy = (gy + 1) % VT;
        end
    endtask

    task automatic run_to_lock(input int limit, output int k);
        k = 0;
        while (!m_locked && k < limit) begin
            pixel(1'b0, 1'b0);
            k++;
        end
        check("lock_reached", o_locked, 1);
    endtask

    task automatic inject_short();
        while (gx != HSS - 1) pixel(1'b0, 1'b0);
        gx = HSS;
        pixel(1'b0, 1'b1);
    endtask

    task automatic inject_wide();
        while (gx != HSE) pixel(1'b0, 1'b0);
        pixel(1'b1, 1'b1);
    endtask

    initial begin
        RST_BTN   = 1'b1;
        i_pix_stb = 1'b0;
        i_hs      = 1'b1;
        i_vs      = 1'b1;
        i_rgb     = '0;
        gx        = 0;
        gy        = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        RST_BTN = 1'b0;
        check_reset_outputs();

        // Clean raster: lock lands on the second vsync fall.
        run_to_lock(400, lat);
        check("lock_latency", lat, HT * VT + VSS * HT + 1);
        repeat (3 * HT * VT) pixel(1'b0, 1'b0);

        // Shortened line, then recovery.
        inject_short();
        check("short_cnt", o_err_cnt, 1);
        check("short_unlocked", o_locked, 0);
        idle(1);
        run_to_lock(400, lat);
        repeat (HT * VT) pixel(1'b0, 1'b0);

        // Widened hsync: counted once at the missing rise.
        inject_wide();
        check("wide_cnt", o_err_cnt, 2);
        repeat (HT) pixel(1'b0, 1'b0);
        check("wide_cnt_once", o_err_cnt, 2);
        run_to_lock(400, lat);

        // Mid-line reset while locked, strobe held low.
        while (gx != 2) pixel(1'b0, 1'b0);
        check("pre_reset_locked", o_locked, 1);
        RST_BTN   = 1'b1;
        i_pix_stb = 1'b0;
        @(posedge CLK);
        #1;
        RST_BTN = 1'b0;
        model_reset();
        check_reset_outputs();
        run_to_lock(400, lat);

        // Saturation of the violation counter.
        max_gap = 0;
        for (int i = 0; i < 300; i++) begin
            run_to_lock(400, lat);
            inject_short();
        end
        check("sat_cnt", o_err_cnt, 255);
        run_to_lock(400, lat);
        inject_wide();
        check("sat_no_wrap", o_err_cnt, 255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- H_TOTAL, 800, pixels per line.
- H_VIS, 640, visible pixels per line.
- H_SS, 656, first pixel of hsync pulse.
- H_SE, 752, first pixel after hsync pulse.
- V_TOTAL, 525, lines per frame.
- V_VIS, 480, visible lines per frame.
- V_SS, 490, first line of vsync pulse.
- V_SE, 492, first line after vsync pulse.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- CLK, in, 1, single system clock, 100 MHz.
- RST_BTN, in, 1, reset; synchronous, active-high.
- i_pix_stb, in, 1, one-CLK pixel strobe, 25 MHz.
- i_hs, in, 1, horizontal sync, active-low.
- i_vs, in, 1, vertical sync, active-low.
- i_rgb, in, 12, {R[3:0],G[3:0],B[3:0]} pixel colour.
- o_x, out, 10, recovered pixel column.
- o_y, out, 10, recovered line.
- o_rgb, out, 12, captured colour.
- o_de, out, 1, visible-pixel valid.
- o_frame_start, out, 1, one-CLK pulse at x=0, y=0 while locked.
- o_locked, out, 1, timing lock indicator.
- o_err, out, 1, one-CLK pulse on timing violation.
- o_err_cnt, out, 8, saturating violation count.

Function
REQ-003 All state SHALL advance only on CLK edges where i_pix_stb=1; with i_pix_stb=0, all state SHALL hold and pulse outputs SHALL be 0.
REQ-004 On each strobe, i_hs/i_vs SHALL be registered into hs_q/vs_q. A fall is current=0, previous=1; a rise is current=1, previous=0.
REQ-005 Internal hcnt (10 b) SHALL predict hn = (hcnt==H_TOTAL-1) ? 0 : hcnt+1 each strobe.
REQ-006 vcnt (10 b) SHALL predict vn = vcnt+1 (wrap V_TOTAL-1 -> 0) only when hn==0, else hold.
REQ-007 On an hs fall, hcnt SHALL load H_SS; otherwise hcnt SHALL load hn.
REQ-008 On a vs fall, vcnt SHALL load V_SS; otherwise vcnt SHALL load per REQ-006.
REQ-009 FSM states SHALL be SEARCH, H_ACQ, V_ACQ, LOCKED; reset state SEARCH.
REQ-010 SEARCH: first hs fall -> H_ACQ.
REQ-011 H_ACQ: hs fall with hn==H_SS -> V_ACQ; hs fall with hn!=H_SS stays H_ACQ (re-anchor).
REQ-012 V_ACQ: first vs fall arms a flag; next vs fall with vn==V_SS and hn==0 -> LOCKED, else clear arm and remain.
REQ-013 Violations, checked in LOCKED only, SHALL be:
- hs fall with hn!=H_SS;
- hs rise with hn!=H_SE;
- vs fall with (vn!=V_SS or hn!=0);
- vs rise with (vn!=V_SE or hn!=0);
- hs low at hn==H_SE (missing rise).
REQ-014 On any violation: o_err SHALL pulse for exactly one CLK; o_err_cnt SHALL increment, saturating at 255; the FSM SHALL go to SEARCH. Multiple violations on one strobe SHALL count once.
REQ-015 o_locked SHALL be 1 exactly while the state is LOCKED.
REQ-016 On each strobe, o_x/o_y SHALL register the updated hcnt/vcnt.
REQ-017 o_rgb SHALL register i_rgb.
REQ-018 o_de SHALL equal LOCKED & x<H_VIS & y<V_VIS, using the same updated counts.
REQ-019 o_x, o_y, o_rgb and o_de SHALL be valid on the CLK after the strobe and held until the next strobe.
REQ-020 o_frame_start SHALL pulse one CLK when LOCKED and updated hcnt==0, vcnt==0.
REQ-021 A violation and a lock transition on the same strobe SHALL resolve to the violation.

Reset
REQ-022 While RST_BTN=1 at a CLK edge (strobe irrelevant), the block SHALL clear:
- hcnt, vcnt, o_x, o_y, o_rgb to 0;
- o_de, o_frame_start, o_locked, o_err to 0;
- o_err_cnt to 0, the V_ACQ arm flag to 0, and the state to SEARCH.
REQ-023 hs_q/vs_q SHALL reset to 1 so that a low sync present at reset release is seen as a fall.
REQ-024 Reset mid-frame SHALL require full reacquisition per REQ-010..012.

Verification
REQ-025 Clean 640x480 stream from reset -> o_locked=1 by the second vs fall; o_frame_start once per 420000 strobes; o_de high 307200 strobes/frame; o_err_cnt=0.
REQ-026 Locked; one line shortened to 799 pixels -> o_err pulse at that hs fall; o_err_cnt=1; o_locked=0; relock after two further vs falls.
REQ-027 Locked; hsync widened to 97 pixels -> violation at hn==752 (missing rise); o_err_cnt increments once only.
REQ-028 Locked; pixel x=5, y=7 driven with i_rgb=0xA5C -> o_x=5, o_y=7, o_rgb=0xA5C, o_de=1 one CLK after that strobe.
REQ-029 Inject 300 violations -> o_err_cnt saturates at 255, no wrap.
REQ-030 Assert RST_BTN for one CLK mid-line while locked -> all outputs 0 next edge; state SEARCH; i_pix_stb=0 during reset has no effect.
